// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two clients (req/ack/done handshake, registered alu_* drive, captured res_*)
module alu_arbiter #(
  parameter int W = 16,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   c0,
  input  logic [3:0]     s0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  input  logic [W-1:0]   c1,
  input  logic [3:0]     s1,
  output logic           ack0,
  output logic           ack1,
  output logic           done0,
  output logic           done1,
  output logic [W-1:0]   res_d,
  output logic [2*W-1:0] res_e,
  output logic           err,
  output logic           busy,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [W-1:0]   alu_c,
  output logic [3:0]     alu_s,
  input  logic [W-1:0]   alu_d,
  input  logic [2*W-1:0] alu_e
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, alu_s_q, alu_s_d;
  logic last_q, last_d, win_q, win_d, ill_q, ill_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, done0_q, done0_d, done1_q, done1_d, err_q, err_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d, res_d_q, res_d_d;
  logic [2*W-1:0] res_e_q, res_e_d;
  logic g1, ill;
  logic [3:0] s_w;
  assign g1 = req1 & (~req0 | ~last_q);
  assign s_w = g1 ? s1 : s0;
  assign ill = s_w[3:1] == 3'b110;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    win_d = win_q;
    ill_d = ill_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_c_d = alu_c_q;
    alu_s_d = alu_s_q;
    res_d_d = res_d_q;
    res_e_d = res_e_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        win_d = g1;
        last_d = g1;
        ack0_d = ~g1;
        ack1_d = g1;
        ill_d = ill;
        state_d = ill ? DONE : EXEC;
        cnt_d = 4'(ALU_LAT - 1);
        alu_a_d = ill ? alu_a_q : (g1 ? a1 : a0);
        alu_b_d = ill ? alu_b_q : (g1 ? b1 : b0);
        alu_c_d = ill ? alu_c_q : (g1 ? c1 : c0);
        alu_s_d = ill ? alu_s_q : s_w;
      end
      EXEC: if (cnt_q == 4'd0) begin
        res_d_d = alu_d;
        res_e_d = alu_e;
        done0_d = ~win_q;
        done1_d = win_q;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE: if (ill_q) begin
        ill_d = 1'b0;
        res_d_d = '0;
        res_e_d = '0;
        done0_d = ~win_q;
        done1_d = win_q;
        err_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      win_q <= 1'b0;
      ill_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_c_q <= '0;
      alu_s_q <= '0;
      res_d_q <= '0;
      res_e_q <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      win_q <= win_d;
      ill_q <= ill_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_c_q <= alu_c_d;
      alu_s_q <= alu_s_d;
      res_d_q <= res_d_d;
      res_e_q <= res_e_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q <= err_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
  assign res_d = res_d_q;
  assign res_e = res_e_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_c = alu_c_q;
  assign alu_s = alu_s_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter at ALU_LAT 1 and 4 against a transaction-level model
module tb_alu_arbiter;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic req0 = 1'b0, req1 = 1'b0, req0_4 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
  logic [3:0] s0 = '0, s1 = '0;
  logic ack0, ack1, done0, done1, err, busy;
  logic [W-1:0] res_d, alu_a, alu_b, alu_c, alu_d;
  logic [2*W-1:0] res_e, alu_e;
  logic [3:0] alu_s;
  logic ack0_4, ack1_4, done0_4, done1_4, err_4, busy_4;
  logic [W-1:0] res_d_4, alu_a_4, alu_b_4, alu_c_4, alu_d_4;
  logic [2*W-1:0] res_e_4, alu_e_4;
  logic [3:0] alu_s_4;
  logic [3*W-1:0] p4 [3];
  alu_arbiter #(.W(W), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .c0(c0), .s0(s0), .a1(a1), .b1(b1), .c1(c1), .s1(s1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .res_d(res_d), .res_e(res_e), .err(err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_s(alu_s),
    .alu_d(alu_d), .alu_e(alu_e));
  alu_arbiter #(.W(W), .ALU_LAT(4)) u4 (
    .clk(clk), .rst(rst), .req0(req0_4), .req1(1'b0),
    .a0(a0), .b0(b0), .c0(c0), .s0(s0), .a1(a1), .b1(b1), .c1(c1), .s1(s1),
    .ack0(ack0_4), .ack1(ack1_4), .done0(done0_4), .done1(done1_4),
    .res_d(res_d_4), .res_e(res_e_4), .err(err_4), .busy(busy_4),
    .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_c(alu_c_4), .alu_s(alu_s_4),
    .alu_d(alu_d_4), .alu_e(alu_e_4));
  assign alu_d = alu_a ^ alu_b;
  assign alu_e = {alu_a, alu_b};
  always_ff @(posedge clk) begin
    p4[0] <= {alu_a_4 ^ alu_b_4, alu_a_4, alu_b_4};
    p4[1] <= p4[0];
    p4[2] <= p4[1];
  end
  assign alu_d_4 = p4[2][3*W-1:2*W];
  assign alu_e_4 = p4[2][2*W-1:0];
  int tests = 0, fails = 0;
  logic last_m = 1'b1;
  logic [3*W+3:0] alu_m = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input bit r0, input bit r1, input int fs);
    logic w, il;
    logic [W-1:0] ea, eb, ec;
    logic [3:0] es;
    if (r0 && !req0) begin
      a0 = W'($urandom); b0 = W'($urandom); c0 = W'($urandom);
      s0 = (fs >= 0) ? fs[3:0] : 4'($urandom);
      req0 = 1'b1;
    end
    if (r1 && !req1) begin
      a1 = W'($urandom); b1 = W'($urandom); c1 = W'($urandom);
      s1 = (fs >= 0) ? fs[3:0] : 4'($urandom);
      req1 = 1'b1;
    end
    w = (req0 && req1) ? !last_m : req1;
    last_m = w;
    ea = w ? a1 : a0; eb = w ? b1 : b0; ec = w ? c1 : c0; es = w ? s1 : s0;
    il = (es == 4'hC) || (es == 4'hD);
    if (!il) alu_m = {ea, eb, ec, es};
    step;
    chk("ack", {ack1, ack0}, w ? 2'b10 : 2'b01);
    chk("busy_ack", busy, 1);
    chk("alu_regs", {alu_a, alu_b, alu_c, alu_s}, alu_m);
    chk("done_early", {done1, done0}, 0);
    if (w) req1 = 1'b0; else req0 = 1'b0;
    step;
    chk("done", {done1, done0}, w ? 2'b10 : 2'b01);
    chk("err", err, il);
    chk("res_d", res_d, il ? 0 : ea ^ eb);
    chk("res_e", res_e, il ? 0 : {ea, eb});
    chk("ack_off", {ack1, ack0}, 0);
    step;
    chk("idle", {busy, done1, done0, err}, 0);
  endtask
  initial begin
    logic [3*W+3:0] v;
    bit x, y;
    step;
    step;
    chk("rst_outs", {ack0, ack1, done0, done1, err, busy, alu_a, alu_b, alu_c, alu_s}, 0);
    chk("rst_res", {res_d, res_e}, 0);
    rst = 1'b0;
    step;
    chk("busy_rst", busy, 0);
    a0 = 16'h2948; b0 = 16'h5A3C; c0 = 16'h762D; s0 = 4'b0000; req0 = 1'b1;
    txn(0, 0, -1);
    chk("single_res_d", res_d, 16'h7374);
    chk("single_res_e", res_e, 32'h29485A3C);
    rst = 1'b1; last_m = 1'b1; alu_m = '0;
    step;
    rst = 1'b0;
    repeat (4) txn(1, 1, -1);
    txn(0, 0, -1);
    txn(0, 1, 13);
    a0 = W'($urandom); b0 = W'($urandom); c0 = W'($urandom); s0 = 4'($urandom_range(0, 11));
    req0_4 = 1'b1;
    step;
    chk("lat_ack", {busy_4, ack1_4, ack0_4}, 3'b101);
    v = {alu_a_4, alu_b_4, alu_c_4, alu_s_4};
    chk("lat_alu", v, {a0, b0, c0, s0});
    req0_4 = 1'b0;
    repeat (3) begin
      step;
      chk("lat_hold", {alu_a_4, alu_b_4, alu_c_4, alu_s_4}, v);
      chk("lat_nodone", {done1_4, done0_4}, 0);
    end
    step;
    chk("lat_done", {done1_4, done0_4, err_4}, 3'b010);
    chk("lat_res_d", res_d_4, a0 ^ b0);
    chk("lat_res_e", res_e_4, {a0, b0});
    step;
    chk("lat_idle", {busy_4, done0_4}, 0);
    a0 = W'($urandom); b0 = W'($urandom); c0 = W'($urandom); s0 = 4'($urandom_range(0, 11));
    req0 = 1'b1;
    step;
    chk("mid_ack", ack0, 1);
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {ack0, ack1, done0, done1, err, busy, alu_a, alu_b, alu_c, alu_s}, 0);
    chk("async_res", {res_d, res_e}, 0);
    #1 rst = 1'b0;
    last_m = 1'b1; alu_m = '0;
    step;
    chk("mid_nodone", {done1, done0, busy}, 0);
    txn(1, 0, $urandom_range(0, 11));
    repeat (24) begin
      x = 1'($urandom);
      y = 1'($urandom);
      if (!x && !y && !req0 && !req1) x = 1'b1;
      txn(x, y, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
